// File: rtl/cdb_broadcaster_pkg.sv
// Shared types and widths for the CDB broadcaster: result entry and FU lane indices.
// Lane order is fixed: LSU, MULT, BTU, ALU.
package cdb_broadcaster_pkg;

    localparam int ROB_TAG_LEN = 6;
    localparam int XLEN        = 32;
    localparam int NUM_FU      = 4;

    localparam int FU_LSU  = 0;
    localparam int FU_MULT = 1;
    localparam int FU_BTU  = 2;
    localparam int FU_ALU  = 3;

    typedef struct packed {
        logic [ROB_TAG_LEN-1:0] tag;
        logic [XLEN-1:0]        value;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_broadcaster_fifo.sv
// Single-lane result FIFO (cdb_fifo): push/pop/flush, head visible combinationally.
// Latency: an entry is visible at head one edge after its push.
// Backpressure: full is derived from registered count only; pushes while full are ignored.
module cdb_fifo
    import cdb_broadcaster_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  cdb_entry_t push_dat,
    output logic       full,
    output logic       empty,
    output cdb_entry_t head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    cdb_entry_t      mem_q [DEPTH];
    cdb_entry_t      mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/cdb_broadcaster.sv
// Buffers FU results per lane and round-robin broadcasts up to CDB_PORTS per cycle on registered wakeup lanes.
// Latency: accept at edge E, wakeup high E+1..E+2; with CDB_BROADCASTER_BYPASS_EN an idle lane can hit E..E+1.
// Backpressure: fu_ready[j] is !full of FIFO j from registered state; a same-cycle pop does not raise it.
module cdb_broadcaster
    import cdb_broadcaster_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int CDB_PORTS  = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                flush,
    input  logic [NUM_FU-1:0]                   fu_valid,
    input  logic [NUM_FU-1:0][ROB_TAG_LEN-1:0]  fu_tag,
    input  logic [NUM_FU-1:0][XLEN-1:0]         fu_value,
    output logic [NUM_FU-1:0]                   fu_ready,
    output logic [NUM_FU-1:0]                   wakeup,
    output logic [NUM_FU-1:0][ROB_TAG_LEN-1:0]  wakeup_tag,
    output logic [NUM_FU-1:0][XLEN-1:0]         wakeup_value,
    output logic                                busy
);

    logic [NUM_FU-1:0]                  full, empty, push, pop, req, grant, byp;
    cdb_entry_t                         head   [NUM_FU];
    cdb_entry_t                         in_ent [NUM_FU];
    cdb_entry_t                         cand   [NUM_FU];
    logic [1:0]                         rr_ptr_q, rr_ptr_d, idx, last;
    int                                 cnt;
    logic [NUM_FU-1:0]                  wakeup_q, wakeup_d;
    logic [NUM_FU-1:0][ROB_TAG_LEN-1:0] wakeup_tag_q, wakeup_tag_d;
    logic [NUM_FU-1:0][XLEN-1:0]        wakeup_value_q, wakeup_value_d;

    for (genvar j = 0; j < NUM_FU; j++) begin : g_fifo
        cdb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .flush    (flush),
            .push     (push[j]),
            .pop      (pop[j]),
            .push_dat (in_ent[j]),
            .full     (full[j]),
            .empty    (empty[j]),
            .head     (head[j])
        );
    end

    // Candidate per lane is the FIFO head, or the live input when bypass lets an empty lane compete.
    always_comb begin
        for (int j = 0; j < NUM_FU; j++) begin
            in_ent[j] = '{tag: fu_tag[j], value: fu_value[j]};
`ifdef CDB_BROADCASTER_BYPASS_EN
            byp[j]    = empty[j] && fu_valid[j];
`else
            byp[j]    = 1'b0;
`endif
            req[j]    = !empty[j] || byp[j];
            cand[j]   = empty[j] ? in_ent[j] : head[j];
        end
    end

    always_comb begin
        grant = '0;
        cnt   = 0;
        idx   = '0;
        last  = rr_ptr_q;
        for (int k = 0; k < NUM_FU; k++) begin
            idx = rr_ptr_q + k[1:0];
            if (req[idx] && cnt < CDB_PORTS) begin
                grant[idx] = 1'b1;
                cnt        = cnt + 1;
                last       = idx;
            end
        end
        if (flush) begin
            rr_ptr_d = '0;
        end else if (|grant) begin
            rr_ptr_d = last + 2'd1;
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    always_comb begin
        push           = fu_valid & ~full & ~(byp & grant) & {NUM_FU{!flush}};
        pop            = grant & ~empty & {NUM_FU{!flush}};
        wakeup_d       = grant;
        wakeup_tag_d   = wakeup_tag_q;
        wakeup_value_d = wakeup_value_q;
        for (int j = 0; j < NUM_FU; j++) begin
            if (grant[j]) begin
                wakeup_tag_d[j]   = cand[j].tag;
                wakeup_value_d[j] = cand[j].value;
            end
        end
        if (flush) begin
            wakeup_d       = '0;
            wakeup_tag_d   = '0;
            wakeup_value_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wakeup_q       <= '0;
            wakeup_tag_q   <= '0;
            wakeup_value_q <= '0;
            rr_ptr_q       <= '0;
        end else begin
            wakeup_q       <= wakeup_d;
            wakeup_tag_q   <= wakeup_tag_d;
            wakeup_value_q <= wakeup_value_d;
            rr_ptr_q       <= rr_ptr_d;
        end
    end

    assign fu_ready     = ~full;
    assign wakeup       = wakeup_q;
    assign wakeup_tag   = wakeup_tag_q;
    assign wakeup_value = wakeup_value_q;
    assign busy         = (|(~empty)) || (|wakeup_q);

    a_port_limit: assert property (@(posedge clk) disable iff (!reset)
        $countones(wakeup_q) <= CDB_PORTS);

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Directed bench: vector table on a 2-port instance, hand sequences on a 1-port instance.
// Covers reset, latency, contention, rotation, flush, backpressure ordering and async reset.
module tb_cdb_broadcaster;
    import cdb_broadcaster_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // 2-port instance
    logic                               flush = 1'b0;
    logic [3:0]                         fu_valid = '0;
    logic [3:0][ROB_TAG_LEN-1:0]        fu_tag = '0;
    logic [3:0][XLEN-1:0]               fu_value = '0;
    logic [3:0]                         fu_ready, wakeup;
    logic [3:0][ROB_TAG_LEN-1:0]        wakeup_tag;
    logic [3:0][XLEN-1:0]               wakeup_value;
    logic                               busy;

    // 1-port instance
    logic                               flush1 = 1'b0;
    logic [3:0]                         fu_valid1 = '0;
    logic [3:0][ROB_TAG_LEN-1:0]        fu_tag1 = '0;
    logic [3:0][XLEN-1:0]               fu_value1 = '0;
    logic [3:0]                         fu_ready1, wakeup1;
    logic [3:0][ROB_TAG_LEN-1:0]        wakeup_tag1;
    logic [3:0][XLEN-1:0]               wakeup_value1;
    logic                               busy1;

    cdb_broadcaster #(.FIFO_DEPTH(2), .CDB_PORTS(2)) dut (
        .clk(clk), .reset(reset), .flush(flush), .fu_valid(fu_valid), .fu_tag(fu_tag),
        .fu_value(fu_value), .fu_ready(fu_ready), .wakeup(wakeup), .wakeup_tag(wakeup_tag),
        .wakeup_value(wakeup_value), .busy(busy));

    cdb_broadcaster #(.FIFO_DEPTH(2), .CDB_PORTS(1)) dut1 (
        .clk(clk), .reset(reset), .flush(flush1), .fu_valid(fu_valid1), .fu_tag(fu_tag1),
        .fu_value(fu_value1), .fu_ready(fu_ready1), .wakeup(wakeup1), .wakeup_tag(wakeup_tag1),
        .wakeup_value(wakeup_value1), .busy(busy1));

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    function automatic logic [31:0] val_of(input logic [5:0] t);
        return 32'hDEA8 + {26'd0, t};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [3:0]       vld;
        logic [3:0][5:0]  tag;
        logic             fl;
        logic [3:0]       ewk;
        logic [3:0][5:0]  etag;
        logic [3:0]       erdy;
        logic             ebusy;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] vld, input logic [23:0] tags, input logic fl,
                                input logic [3:0] ewk, input logic [23:0] etags,
                                input logic [3:0] erdy, input logic ebusy);
        vec_t v;
        v.vld = vld; v.tag = tags; v.fl = fl;
        v.ewk = ewk; v.etag = etags; v.erdy = erdy; v.ebusy = ebusy;
        return v;
    endfunction

    vec_t vecs [19];

    logic [5:0] expq [4][$];
    int         sent [4];
    int         occ  [4];
    logic [3:0] acc;
    logic       saw_full;
    int         nbcast;

    initial begin
        // tag fields below are {lane3, lane2, lane1, lane0}
        vecs[0]  = mk(4'b0000, 24'd0, 0, 4'b0000, 24'd0, 4'hF, 0);
        vecs[1]  = mk(4'b1000, {6'd5, 18'd0}, 0, 4'b0000, 24'd0, 4'hF, 1);
        vecs[2]  = mk(4'b0000, 24'd0, 0, 4'b1000, {6'd5, 18'd0}, 4'hF, 1);
        vecs[3]  = mk(4'b0000, 24'd0, 0, 4'b0000, 24'd0, 4'hF, 0);
        vecs[4]  = mk(4'b1111, {6'd4, 6'd3, 6'd2, 6'd1}, 0, 4'b0000, 24'd0, 4'hF, 1);
        vecs[5]  = mk(4'b0000, 24'd0, 0, 4'b0011, {6'd0, 6'd0, 6'd2, 6'd1}, 4'hF, 1);
        vecs[6]  = mk(4'b0000, 24'd0, 0, 4'b1100, {6'd4, 6'd3, 6'd0, 6'd0}, 4'hF, 1);
        vecs[7]  = mk(4'b0000, 24'd0, 0, 4'b0000, 24'd0, 4'hF, 0);
        vecs[8]  = mk(4'b0111, {6'd0, 6'd12, 6'd11, 6'd10}, 0, 4'b0000, 24'd0, 4'hF, 1);
        vecs[9]  = mk(4'b0000, 24'd0, 0, 4'b0011, {6'd0, 6'd0, 6'd11, 6'd10}, 4'hF, 1);
        vecs[10] = mk(4'b0000, 24'd0, 0, 4'b0100, {6'd0, 6'd12, 6'd0, 6'd0}, 4'hF, 1);
        vecs[11] = mk(4'b0000, 24'd0, 0, 4'b0000, 24'd0, 4'hF, 0);
        vecs[12] = mk(4'b0010, {12'd0, 6'd7, 6'd0}, 0, 4'b0000, 24'd0, 4'hF, 1);
        vecs[13] = mk(4'b0010, {12'd0, 6'd8, 6'd0}, 1, 4'b0000, 24'd0, 4'hF, 0);
        vecs[14] = mk(4'b0000, 24'd0, 0, 4'b0000, 24'd0, 4'hF, 0);
        vecs[15] = mk(4'b1101, {6'd23, 6'd22, 6'd0, 6'd20}, 0, 4'b0000, 24'd0, 4'hF, 1);
        vecs[16] = mk(4'b0000, 24'd0, 0, 4'b0101, {6'd0, 6'd22, 6'd0, 6'd20}, 4'hF, 1);
        vecs[17] = mk(4'b0000, 24'd0, 0, 4'b1000, {6'd23, 18'd0}, 4'hF, 1);
        vecs[18] = mk(4'b0000, 24'd0, 0, 4'b0000, 24'd0, 4'hF, 0);

        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        check("reset wakeup", wakeup, 4'h0);
        check("reset fu_ready", fu_ready, 4'hF);
        check("reset busy", busy, 1'b0);
        check("reset wakeup 1p", wakeup1, 4'h0);
        tick();

        for (int i = 0; i < 19; i++) begin
            fu_valid = vecs[i].vld;
            flush    = vecs[i].fl;
            for (int j = 0; j < 4; j++) begin
                fu_tag[j]   = vecs[i].tag[j];
                fu_value[j] = val_of(vecs[i].tag[j]);
            end
            tick();
            check($sformatf("row%0d wakeup", i), wakeup, vecs[i].ewk);
            check($sformatf("row%0d fu_ready", i), fu_ready, vecs[i].erdy);
            check($sformatf("row%0d busy", i), busy, vecs[i].ebusy);
            for (int j = 0; j < 4; j++) begin
                if (vecs[i].ewk[j]) begin
                    check($sformatf("row%0d tag%0d", i, j), wakeup_tag[j], vecs[i].etag[j]);
                    check($sformatf("row%0d value%0d", i, j), wakeup_value[j], val_of(vecs[i].etag[j]));
                end
            end
        end
        fu_valid = '0;
        flush    = 1'b0;

        // Backpressure on the 1-port instance: four results per FU, all valids held high.
        saw_full = 1'b0;
        nbcast   = 0;
        for (int j = 0; j < 4; j++) begin
            sent[j] = 0;
            occ[j]  = 0;
        end
        for (int c = 0; c < 40; c++) begin
            for (int j = 0; j < 4; j++) begin
                fu_valid1[j] = (sent[j] < 4);
                fu_tag1[j]   = {j[1:0], sent[j][3:0]};
                fu_value1[j] = val_of({j[1:0], sent[j][3:0]});
            end
            acc = fu_valid1 & fu_ready1;
            tick();
            for (int j = 0; j < 4; j++) begin
                if (acc[j]) begin
                    expq[j].push_back(fu_tag1[j]);
                    sent[j]++;
                    occ[j]++;
                end
            end
            check("bp popcount", ($countones(wakeup1) <= 1), 1'b1);
            for (int j = 0; j < 4; j++) begin
                if (wakeup1[j]) begin
                    nbcast++;
                    if (expq[j].size() == 0) begin
                        check($sformatf("bp lane%0d spurious", j), wakeup1[j], 1'b0);
                    end else begin
                        check($sformatf("bp lane%0d tag", j), wakeup_tag1[j], expq[j][0]);
                        check($sformatf("bp lane%0d value", j), wakeup_value1[j], val_of(expq[j][0]));
                        void'(expq[j].pop_front());
                        occ[j]--;
                    end
                end
            end
            for (int j = 0; j < 4; j++) begin
                if (occ[j] >= 2) saw_full = 1'b1;
                check($sformatf("bp fu_ready%0d", j), fu_ready1[j], (occ[j] < 2));
            end
        end
        fu_valid1 = '0;
        check("bp saw full", saw_full, 1'b1);
        check("bp broadcasts", nbcast, 16);
        check("bp busy drained", busy1, 1'b0);

        // Async reset between edges while the 2-port instance broadcasts.
        fu_valid = 4'hF;
        for (int j = 0; j < 4; j++) begin
            fu_tag[j]   = 6'(40 + j);
            fu_value[j] = val_of(6'(40 + j));
        end
        tick();
        fu_valid = '0;
        tick();
        check("burst wakeup before reset", wakeup, 4'b0011);
        #3 reset = 1'b0;
        #1;
        check("async reset wakeup", wakeup, 4'h0);
        check("async reset busy", busy, 1'b0);
        #2 reset = 1'b1;
        tick();
        check("post reset wakeup a", wakeup, 4'h0);
        check("post reset busy", busy, 1'b0);
        tick();
        check("post reset wakeup b", wakeup, 4'h0);

        // Flush on 1-port instance with MULT holding tags 7 and 8.
        fu_valid1 = 4'hF;
        fu_tag1   = {6'd33, 6'd32, 6'd7, 6'd30};
        for (int j = 0; j < 4; j++) fu_value1[j] = val_of(fu_tag1[j]);
        tick();
        fu_valid1 = 4'b0010;
        fu_tag1[1]   = 6'd8;
        fu_value1[1] = val_of(6'd8);
        tick();
        check("fl first bcast", wakeup1, 4'b0001);
        check("fl first tag", wakeup_tag1[0], 6'd30);
        check("fl mult full", fu_ready1[1], 1'b0);
        fu_valid1 = 4'hF;
        fu_tag1   = {6'd9, 6'd9, 6'd9, 6'd9};
        for (int j = 0; j < 4; j++) fu_value1[j] = val_of(6'd9);
        flush1 = 1'b1;
        tick();
        flush1    = 1'b0;
        fu_valid1 = '0;
        check("fl wakeup", wakeup1, 4'h0);
        check("fl busy", busy1, 1'b0);
        check("fl fu_ready", fu_ready1, 4'hF);
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("fl quiet%0d", c), wakeup1, 4'h0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
